// File: rtl/cpu_run_ctrl.sv
`default_nettype none
//==============================================================================
// cpu_run_ctrl: conditions board controls and sequences the 6502 through reset/halt/step/run.  Rev 1.0
//==============================================================================
module cpu_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int RUN_DIV         = 4,
  parameter int RST_CYCLES      = 8
) (
  input  logic        clk_i,
  input  logic        reset_n_i,
  input  logic        btn_step_i,
  input  logic        btn_reset_i,
  input  logic        sw_run_i,
  output logic        cpu_ce_o,
  output logic        cpu_rst_n_o,
  output logic [1:0]  mode_o,
  output logic [15:0] ce_count_o
);

  localparam int C_NIN      = 3;
  localparam int C_IDX_STEP = 0;
  localparam int C_IDX_RST  = 1;
  localparam int C_IDX_RUN  = 2;
  localparam int DB_W       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DIV_W      = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam int RST_W      = $clog2(RST_CYCLES + 1);

  localparam logic [DB_W-1:0]  C_DB_LIMIT = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(RUN_DIV - 1);
  localparam logic [RST_W-1:0] C_RST_LOAD = RST_W'(RST_CYCLES);

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_HALT  = 2'b01,
    ST_STEP  = 2'b10,
    ST_RUN   = 2'b11
  } state_t;

  logic [C_NIN-1:0] w_raw;
  logic [C_NIN-1:0] sync1_q;
  logic [C_NIN-1:0] sync2_q;
  logic [C_NIN-1:0] db_q;
  logic [DB_W-1:0]  db_cnt_q [C_NIN];
  logic             step_prev_q;
  logic             w_step_pulse;

  assign w_raw = {sw_run_i, btn_reset_i, btn_step_i};

  // A new level is accepted only after DEBOUNCE_CYCLES+1 consecutive differing samples.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      db_q        <= '0;
      step_prev_q <= 1'b0;
      for (int i = 0; i < C_NIN; i++) db_cnt_q[i] <= '0;
    end else begin
      sync1_q     <= w_raw;
      sync2_q     <= sync1_q;
      step_prev_q <= db_q[C_IDX_STEP];
      for (int i = 0; i < C_NIN; i++) begin
        if (sync2_q[i] == db_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == C_DB_LIMIT) begin
          db_q[i]     <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_step_pulse = db_q[C_IDX_STEP] & ~step_prev_q;

  state_t           state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] w_div_next;
  logic [RST_W-1:0] rst_cnt_q;
  logic             cpu_ce_q;
  logic             cpu_rst_n_q;
  logic [15:0]      ce_count_q;

  assign w_div_next = (div_q == C_DIV_LAST) ? '0 : div_q + DIV_W'(1);

  always_ff @(posedge clk_i) begin
    if (!reset_n_i || db_q[C_IDX_RST]) begin
      state_q     <= ST_RESET;
      rst_cnt_q   <= C_RST_LOAD;
      div_q       <= '0;
      cpu_ce_q    <= 1'b0;
      cpu_rst_n_q <= 1'b0;
      ce_count_q  <= '0;
    end else begin
      cpu_ce_q   <= 1'b0;
      ce_count_q <= ce_count_q + {15'd0, cpu_ce_q};
      case (state_q)
        ST_RESET: begin
          ce_count_q <= '0;
          rst_cnt_q  <= rst_cnt_q - RST_W'(1);
          if (rst_cnt_q <= RST_W'(1)) begin
            state_q     <= ST_HALT;
            cpu_rst_n_q <= 1'b1;
          end
        end
        ST_HALT: begin
          if (db_q[C_IDX_RUN]) begin
            state_q  <= ST_RUN;
            div_q    <= '0;
            cpu_ce_q <= (C_DIV_LAST == '0);
          end else if (w_step_pulse) begin
            state_q  <= ST_STEP;
            cpu_ce_q <= 1'b1;
          end
        end
        ST_STEP: begin
          state_q <= ST_HALT;
        end
        ST_RUN: begin
          // Leaving RUN drops the partial divider count; no trailing pulse.
          if (!db_q[C_IDX_RUN]) begin
            state_q <= ST_HALT;
            div_q   <= '0;
          end else begin
            div_q    <= w_div_next;
            cpu_ce_q <= (w_div_next == C_DIV_LAST);
          end
        end
        default: state_q <= ST_RESET;
      endcase
    end
  end

  assign cpu_ce_o    = cpu_ce_q;
  assign cpu_rst_n_o = cpu_rst_n_q;
  assign mode_o      = state_q;
  assign ce_count_o  = ce_count_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_run_ctrl.sv
`default_nettype none
//==============================================================================
// tb_cpu_run_ctrl: directed stimulus with a cycle-level behavioural model.  Rev 1.0
//==============================================================================
module tb_cpu_run_ctrl;
  localparam int DEB  = 4;
  localparam int DIV  = 4;
  localparam int RSTC = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        btn_step = 1'b0;
  logic        btn_reset = 1'b0;
  logic        sw_run = 1'b0;
  logic        cpu_ce;
  logic        cpu_rst_n;
  logic [1:0]  mode;
  logic [15:0] ce_count;

  always #5 clk = ~clk;

  cpu_run_ctrl #(
    .DEBOUNCE_CYCLES(DEB),
    .RUN_DIV        (DIV),
    .RST_CYCLES     (RSTC)
  ) dut (
    .clk_i      (clk),
    .reset_n_i  (reset_n),
    .btn_step_i (btn_step),
    .btn_reset_i(btn_reset),
    .sw_run_i   (sw_run),
    .cpu_ce_o   (cpu_ce),
    .cpu_rst_n_o(cpu_rst_n),
    .mode_o     (mode),
    .ce_count_o (ce_count)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: mode 0 RESET, 1 HALT, 2 STEP, 3 RUN. Inputs: 0 step, 1 reset, 2 run.
  int          m_mode = 0;
  int          m_rst_left = RSTC;
  int          m_age = 0;
  bit          m_ce = 1'b0;
  logic [15:0] m_count = '0;
  bit          m_s1 [3];
  bit          m_s2 [3];
  bit          m_db [3];
  int          m_diff_len [3];
  bit          m_rose = 1'b0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    bit ce_n;
    bit raw [3];
    raw[0] = btn_step;
    raw[1] = btn_reset;
    raw[2] = sw_run;
    ce_n = 1'b0;
    if (!reset_n) begin
      m_mode = 0; m_rst_left = RSTC; m_count = '0; m_age = 0; m_rose = 1'b0;
      for (int i = 0; i < 3; i++) begin
        m_s1[i] = 1'b0; m_s2[i] = 1'b0; m_db[i] = 1'b0; m_diff_len[i] = 0;
      end
    end else begin
      if (m_db[1]) begin
        m_mode = 0; m_rst_left = RSTC; m_count = '0;
      end else begin
        m_count = (m_mode == 0) ? 16'h0000 : m_count + 16'(m_ce);
        case (m_mode)
          0: begin
            m_rst_left--;
            if (m_rst_left == 0) m_mode = 1;
          end
          1: begin
            if (m_db[2]) begin m_mode = 3; m_age = 0; ce_n = (DIV == 1); end
            else if (m_rose) begin m_mode = 2; ce_n = 1'b1; end
          end
          2: m_mode = 1;
          default: begin
            if (!m_db[2]) m_mode = 1;
            else begin m_age++; ce_n = ((m_age % DIV) == DIV - 1); end
          end
        endcase
      end
      m_rose = 1'b0;
      for (int i = 0; i < 3; i++) begin
        if (m_s2[i] != m_db[i]) begin
          m_diff_len[i]++;
          if (m_diff_len[i] > DEB) begin
            m_db[i] = m_s2[i];
            m_diff_len[i] = 0;
            if (i == 0 && m_db[0]) m_rose = 1'b1;
          end
        end else begin
          m_diff_len[i] = 0;
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = raw[i];
      end
    end
    m_ce = ce_n;
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("model_mode", 32'(mode), 32'(m_mode));
      check("model_cpu_ce", 32'(cpu_ce), 32'(m_ce));
      check("model_cpu_rst_n", 32'(cpu_rst_n), 32'(m_mode != 0));
      check("model_ce_count", 32'(ce_count), 32'(m_count));
    end
  end

  task automatic wait_mode(input logic [1:0] m, input int maxc, input string name);
    int k = 0;
    while (mode !== m && k < maxc) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(mode), 32'(m));
  endtask

  task automatic press_step(output int pulses, output int steps);
    pulses = 0;
    steps  = 0;
    btn_step = 1'b1;
    for (int i = 0; i < 65; i++) begin
      if (i == 50) btn_step = 1'b0;
      @(negedge clk);
      if (cpu_ce) pulses++;
      if (mode == 2'b10) steps++;
    end
  endtask

  initial begin
    int low, pulses, steps, bad_mode, start, halt_cycles;
    bit seen_reset;
    @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Power-up reset pulse
    low = 0;
    while (cpu_rst_n == 1'b0 && low < 50) begin
      low++;
      @(negedge clk);
    end
    check("pwrup_rst_low_cycles", 32'(low), 32'd8);
    check("pwrup_mode", 32'(mode), 32'h1);
    check("pwrup_ce", 32'(cpu_ce), 32'h0);
    check("pwrup_count", 32'(ce_count), 32'h0);

    // Two step presses, each held long
    press_step(pulses, steps);
    check("step1_pulses", 32'(pulses), 32'd1);
    check("step1_mode_cycles", 32'(steps), 32'd1);
    check("step1_count", 32'(ce_count), 32'd1);
    press_step(pulses, steps);
    check("step2_pulses", 32'(pulses), 32'd1);
    check("step2_count", 32'(ce_count), 32'd2);

    // Bouncing step button
    pulses = 0;
    bad_mode = 0;
    for (int i = 0; i < 50; i++) begin
      btn_step = (i < 40) ? (((i / 2) % 2) == 0) : 1'b0;
      @(negedge clk);
      if (cpu_ce) pulses++;
      if (mode != 2'b01) bad_mode++;
    end
    check("bounce_pulses", 32'(pulses), 32'd0);
    check("bounce_mode", 32'(bad_mode), 32'd0);

    // Free run for 40 cycles
    sw_run = 1'b1;
    wait_mode(2'b11, 20, "run_enter");
    start  = int'(ce_count);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (cpu_ce) pulses++;
      @(negedge clk);
    end
    check("run_pulses_40", 32'(pulses), 32'd10);
    check("run_count_40", 32'(ce_count), 32'(start + 10));

    // Counter wrap: preload just after a pulse has been counted
    low = 0;
    while (cpu_ce !== 1'b1 && low < 10) begin @(negedge clk); low++; end
    @(negedge clk);
    check("wrap_preload_ce_idle", 32'(cpu_ce), 32'h0);
    force dut.ce_count_q = 16'hFFFE;
    m_count = 16'hFFFE;
    #1;
    release dut.ce_count_q;
    low = 0;
    while (cpu_ce !== 1'b1 && low < 10) begin @(negedge clk); low++; end
    @(negedge clk);
    check("wrap_ffff", 32'(ce_count), 32'hFFFF);
    low = 0;
    while (cpu_ce !== 1'b1 && low < 10) begin @(negedge clk); low++; end
    @(negedge clk);
    check("wrap_0000", 32'(ce_count), 32'h0000);

    // Run switch off
    sw_run = 1'b0;
    wait_mode(2'b01, 20, "run_exit");
    pulses = 0;
    bad_mode = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cpu_ce) pulses++;
      if (mode != 2'b01) bad_mode++;
    end
    check("halt_no_pulses", 32'(pulses), 32'd0);
    check("halt_mode", 32'(bad_mode), 32'd0);

    // Reset button mid-run, run switch left on
    sw_run = 1'b1;
    wait_mode(2'b11, 20, "run_reenter");
    repeat (2) @(negedge clk);
    btn_reset   = 1'b1;
    low         = 0;
    halt_cycles = 0;
    seen_reset  = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i == 10) btn_reset = 1'b0;
      if (cpu_rst_n == 1'b0) low++;
      if (mode == 2'b00 && !seen_reset) begin
        seen_reset = 1'b1;
        check("rst_ce_stops", 32'(cpu_ce), 32'h0);
        check("rst_count_clear", 32'(ce_count), 32'h0);
      end
      if (seen_reset && mode == 2'b01) halt_cycles++;
      @(negedge clk);
    end
    check("rst_seen", 32'(seen_reset), 32'h1);
    check("rst_low_cycles", 32'(low), 32'd17);
    check("rst_halt_cycles", 32'(halt_cycles), 32'd1);
    check("rst_back_to_run", 32'(mode), 32'h3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
